pwm_counter: RTL and testbench

- Time-base stage directly upstream of the PWM output generator.
- Produces the free-running count value that the generator compares against its compare registers.
- Provides a programmable prescaler, up or down counting, a shadowed period that reloads only at cycle boundaries, and a one-cycle period-boundary pulse.

---
 rtl/pwm_counter.sv | 123 ++++++++++++
 tb/tb_pwm_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pwm_counter.sv
// PWM time base: prescaled up/down counter with shadowed period/mode and a reload pulse.
// Optional macro PWM_CNT_CENTER_EN turns down=1 into center-aligned up/down counting.
module pwm_counter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             count_reset,
  input  logic [WIDTH-1:0] period,
  input  logic [PSC_W-1:0] prescale,
  input  logic             down,
  output logic [WIDTH-1:0] count_val,
  output logic             period_done,
  output logic             cnt_dir
);

  logic [PSC_W-1:0] psc_cnt, psc_nxt;
  logic [WIDTH-1:0] per_sh, per_nxt;
  logic             mode_sh, mode_nxt;
  logic [WIDTH-1:0] cnt_nxt, cnt_inc, cnt_dec;
  logic             done_nxt, dir_nxt;
  logic             tick, reload;

  assign tick    = (psc_cnt == prescale);
  assign cnt_inc = count_val + 1'b1;
  assign cnt_dec = count_val - 1'b1;

  always_comb begin
    psc_nxt  = psc_cnt;
    per_nxt  = per_sh;
    mode_nxt = mode_sh;
    cnt_nxt  = count_val;
    dir_nxt  = cnt_dir;
    done_nxt = 1'b0;
    reload   = 1'b0;
    if (count_reset) begin
      psc_nxt  = '0;
      per_nxt  = period;
      mode_nxt = down;
      cnt_nxt  = down ? period : '0;
`ifdef PWM_CNT_CENTER_EN
      // Restarting at the top of a center cycle means descending next.
      dir_nxt  = down && (period != '0);
`else
      dir_nxt  = down;
`endif
    end else if (!en) begin
      per_nxt  = period;
      mode_nxt = down;
    end else begin
      psc_nxt = tick ? '0 : psc_cnt + 1'b1;
      if (tick) begin
`ifdef PWM_CNT_CENTER_EN
        if (mode_sh) begin
          if (!cnt_dir) begin
            if (count_val == per_sh) begin
              reload = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
              dir_nxt = (cnt_inc == per_sh);
            end
          end else begin
            if (count_val == '0 || count_val == WIDTH'(1)) begin
              reload = 1'b1;
            end else begin
              cnt_nxt = cnt_dec;
            end
          end
        end else begin
          if (count_val == per_sh) reload = 1'b1;
          else                     cnt_nxt = cnt_inc;
          dir_nxt = 1'b0;
        end
        if (reload) begin
          per_nxt  = period;
          mode_nxt = down;
          done_nxt = 1'b1;
          cnt_nxt  = '0;
          dir_nxt  = 1'b0;
        end
`else
        if (!mode_sh) begin
          if (count_val == per_sh) reload = 1'b1;
          else                     cnt_nxt = cnt_inc;
        end else begin
          if (count_val == '0) reload = 1'b1;
          else                 cnt_nxt = cnt_dec;
        end
        dir_nxt = mode_sh;
        // Reload value and direction follow the freshly shadowed mode.
        if (reload) begin
          per_nxt  = period;
          mode_nxt = down;
          done_nxt = 1'b1;
          cnt_nxt  = down ? period : '0;
          dir_nxt  = down;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_val   <= '0;
      period_done <= 1'b0;
      cnt_dir     <= 1'b0;
      psc_cnt     <= '0;
      per_sh      <= '0;
      mode_sh     <= 1'b0;
    end else begin
      count_val   <= cnt_nxt;
      period_done <= done_nxt;
      cnt_dir     <= dir_nxt;
      psc_cnt     <= psc_nxt;
      per_sh      <= per_nxt;
      mode_sh     <= mode_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_counter.sv
// Directed vector bench for pwm_counter; center-mode vectors used when PWM_CNT_CENTER_EN is defined.
module tb_pwm_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        count_reset;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic        down;
  logic [15:0] count_val;
  logic        period_done;
  logic        cnt_dir;

  int checks   = 0;
  int failures = 0;

  pwm_counter #(.WIDTH(16), .PSC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .count_reset(count_reset),
    .period(period), .prescale(prescale), .down(down),
    .count_val(count_val), .period_done(period_done), .cnt_dir(cnt_dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        cr;
    logic [15:0] period;
    logic [7:0]  prescale;
    logic        down;
    logic [15:0] exp_cnt;
    logic        exp_done;
    logic        exp_dir;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic e, logic c, logic [15:0] p, logic [7:0] ps, logic d,
                              logic [15:0] xc, logic xd, logic xr);
    vec_t v;
    v.en = e; v.cr = c; v.period = p; v.prescale = ps; v.down = d;
    v.exp_cnt = xc; v.exp_done = xd; v.exp_dir = xr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] c, input logic d, input logic r);
    chk({name, ".count_val"}, 32'(count_val), 32'(c));
    chk({name, ".period_done"}, 32'(period_done), 32'(d));
    chk({name, ".cnt_dir"}, 32'(cnt_dir), 32'(r));
  endtask

  task automatic step(input logic e, input logic c, input logic [15:0] p, input logic [7:0] ps,
                      input logic d);
    en = e; count_reset = c; period = p; prescale = ps; down = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; count_reset = 1'b0; period = '0; prescale = '0; down = 1'b0;

    // Up count, period 4, with an en hold at count 2
    add(0,0,4,0,0, 0,0,0);
    for (int i = 1; i <= 4; i++) add(1,0,4,0,0, 16'(i),0,0);
    add(1,0,4,0,0, 0,1,0);
    add(1,0,4,0,0, 1,0,0);
    add(1,0,4,0,0, 2,0,0);
    for (int i = 0; i < 5; i++) add(0,0,4,0,0, 2,0,0);
    add(1,0,4,0,0, 3,0,0);
    add(1,0,4,0,0, 4,0,0);
    add(1,0,4,0,0, 0,1,0);
`ifdef PWM_CNT_CENTER_EN
    add(1,1,2,0,1, 2,0,1);
    add(1,0,2,0,1, 1,0,1);
    add(1,0,2,0,1, 0,1,0);
    add(1,0,2,0,1, 1,0,0);
    add(1,0,2,0,1, 2,0,1);
    add(1,0,2,0,1, 1,0,1);
    add(1,0,2,0,1, 0,1,0);
`else
    // Down count 3,2,1,0,3,2 then period shrinks mid-cycle
    add(1,1,3,0,1, 3,0,1);
    add(1,0,3,0,1, 2,0,1);
    add(1,0,3,0,1, 1,0,1);
    add(1,0,3,0,1, 0,0,1);
    add(1,0,3,0,1, 3,1,1);
    add(1,0,3,0,1, 2,0,1);
    add(1,0,1,0,1, 1,0,1);
    add(1,0,1,0,1, 0,0,1);
    add(1,0,1,0,1, 1,1,1);
    add(1,0,1,0,1, 0,0,1);
    add(1,0,1,0,1, 1,1,1);
    // Switch to up at the boundary: reload value is 0
    add(1,0,2,0,0, 0,0,1);
    add(1,0,2,0,0, 0,1,0);
    add(1,0,2,0,0, 1,0,0);
    add(1,0,2,0,0, 2,0,0);
    add(1,0,2,0,0, 0,1,0);
`endif
    add(1,1,9,0,0, 0,0,0);
    for (int i = 1; i <= 7; i++) add(1,0,9,0,0, 16'(i),0,0);
`ifndef PWM_CNT_CENTER_EN
    add(1,1,9,0,1, 9,0,1);
    add(1,0,9,0,1, 8,0,1);
`endif
    // Period 0: count stays 0, pulse every tick
    add(1,1,0,0,0, 0,0,0);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0, 0,1,0);
    add(0,0,0,0,0, 0,0,0);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reset_release", 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].cr, vecs[i].period, vecs[i].prescale, vecs[i].down);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_done, vecs[i].exp_dir);
    end

    // Prescale 2, period 3: one step per 3 clk, done every 12 clk
    step(1, 1, 3, 2, 0);
    chk_all("psc_start", 0, 0, 0);
    for (int i = 1; i <= 24; i++) begin
      step(1, 0, 3, 2, 0);
      chk_all($sformatf("psc_c%0d", i), 16'((i / 3) % 4), (i % 12) == 0, 0);
    end
    step(1, 0, 3, 2, 0);
    chk_all("psc_c25", 0, 0, 0);
    step(1, 0, 3, 2, 0);
    chk_all("psc_c26", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 3, 2, 0);
      chk_all($sformatf("psc_hold%0d", i), 0, 0, 0);
    end
    step(1, 0, 3, 2, 0);
    chk_all("psc_resume", 1, 0, 0);

    // Asynchronous reset in the middle of a clock period
    step(1, 1, 9, 0, 1);
    step(1, 0, 9, 0, 1);
    chk("pre_rst.count_val", 32'(count_val), 32'd8);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0);
    #2;
    rst_n = 1'b1;
    en = 1'b0;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
